// File: rtl/mips_regfile.sv
// MIPS register file: 31 stored registers plus hardwired $0, two combinational
// read ports with write-through forwarding and one synchronous write port.
module mips_regfile #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [4:0]       wa,
    input  logic [WIDTH-1:0] wd,
    output logic             wr_done
);

    logic [WIDTH-1:0] regs_q [NREG-1:1];
    logic             wr_done_q;
    logic             wr_done_d;
    logic             wr_accept;

    assign wr_accept = we && (wa != 5'd0);
    assign wr_done_d = wr_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wr_done_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                regs_q[wa] <= wd;
            end
            wr_done_q <= wr_done_d;
        end
    end

    // Reset gates the read path too, so a forwarded wd cannot leak out while held in reset.
    always_comb begin
        rd1 = '0;
        if (rst_n && (ra1 != 5'd0)) begin
            if (we && (wa == ra1)) begin
                rd1 = wd;
            end else begin
                rd1 = regs_q[ra1];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (rst_n && (ra2 != 5'd0)) begin
            if (we && (wa == ra2)) begin
                rd2 = wd;
            end else begin
                rd2 = regs_q[ra2];
            end
        end
    end

    assign wr_done = wr_done_q;

endmodule
